// File: rtl/conv_job_scheduler.sv
// Job FIFO plus sequencer that runs queued convolution jobs one at a time on conv2d.
// Optional watchdog abort enabled by defining CONV_SCHED_TIMEOUT_EN.
module conv_job_scheduler #(
    parameter int unsigned AddressBitWidth = 17,
    parameter int unsigned QueueDepth      = 4,
    parameter int unsigned QueuePtrWidth   = 2,
    parameter int unsigned TimeoutBitWidth = 16,
    parameter int unsigned TimeoutCycles   = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [AddressBitWidth-1:0] job_src_base,
    input  logic [AddressBitWidth-1:0] job_dst_base,
    output logic                       conv_rst,
    output logic                       conv_start,
    input  logic                       conv_ready,
    input  logic [AddressBitWidth-1:0] conv_rd_addr,
    input  logic [AddressBitWidth-1:0] conv_wr_addr,
    input  logic                       conv_we,
    output logic [AddressBitWidth-1:0] mem_rd_addr,
    output logic [AddressBitWidth-1:0] mem_wr_addr,
    output logic                       mem_we,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 jobs_done,
    output logic                       error
);

    if (QueueDepth != (1 << QueuePtrWidth) || QueueDepth < 2 ||
        TimeoutCycles < 1 || TimeoutCycles >= (1 << TimeoutBitWidth)) begin : g_bad_params
        $error("conv_job_scheduler: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_START,
        S_RUN,
`ifdef CONV_SCHED_TIMEOUT_EN
        S_ABORT,
`endif
        S_DONE
    } state_e;

    localparam logic [QueuePtrWidth:0] DepthCount = (QueuePtrWidth + 1)'(QueueDepth);

    state_e                     state_q, state_d;
    logic [AddressBitWidth-1:0] src_mem_q [QueueDepth];
    logic [AddressBitWidth-1:0] dst_mem_q [QueueDepth];
    logic [QueuePtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [QueuePtrWidth:0]     count_q, count_d;
    logic [AddressBitWidth-1:0] src_base_q, dst_base_q;
    logic [7:0]                 jobs_done_q;
    logic                       push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign job_ready  = (count_q != DepthCount);
    assign push       = job_valid && job_ready;

`ifdef CONV_SCHED_TIMEOUT_EN
    localparam logic [TimeoutBitWidth-1:0] TimeoutLast = TimeoutBitWidth'(TimeoutCycles - 1);
    logic [TimeoutBitWidth-1:0] tmo_q, tmo_d;
    logic                       error_q;
`endif

    always_comb begin
        state_d    = state_q;
        conv_rst   = 1'b0;
        conv_start = 1'b0;
        done       = 1'b0;
        pop        = 1'b0;
`ifdef CONV_SCHED_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                conv_rst = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                conv_rst = 1'b1;
                state_d  = S_START;
            end
            S_START: begin
                conv_start = 1'b1;
                state_d    = S_RUN;
`ifdef CONV_SCHED_TIMEOUT_EN
                tmo_d      = '0;
`endif
            end
            S_RUN: begin
`ifdef CONV_SCHED_TIMEOUT_EN
                tmo_d = tmo_q + 1'b1;
                // ready arriving in the expiry cycle still completes the job
                if (conv_ready)               state_d = S_DONE;
                else if (tmo_q == TimeoutLast) state_d = S_ABORT;
`else
                if (conv_ready) state_d = S_DONE;
`endif
            end
            S_DONE: begin
                done = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = S_CLR;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef CONV_SCHED_TIMEOUT_EN
            S_ABORT: begin
                conv_rst = 1'b1;
                state_d  = S_IDLE;
            end
`endif
            default: begin
                conv_rst = 1'b1;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            src_mem_q[wr_ptr_q] <= job_src_base;
            dst_mem_q[wr_ptr_q] <= job_dst_base;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            jobs_done_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                src_base_q <= src_mem_q[rd_ptr_q];
                dst_base_q <= dst_mem_q[rd_ptr_q];
            end
            if (state_q == S_DONE) jobs_done_q <= jobs_done_q + 8'd1;
        end
    end

`ifdef CONV_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            if (state_q == S_ABORT) error_q <= 1'b1;
        end
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign mem_rd_addr = src_base_q + conv_rd_addr;
    assign mem_wr_addr = dst_base_q + conv_wr_addr;
    // DONE keeps the engine's delayed final write
    assign mem_we      = conv_we && ((state_q == S_RUN) || (state_q == S_DONE));
    assign busy        = (state_q != S_IDLE) || !fifo_empty;
    assign jobs_done   = jobs_done_q;

endmodule
